// File: rtl/core_dec_pkg.sv
// Shared decode definitions: RV32 base opcodes and immediate-format classification.
package core_dec_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_type_e;

  // Unrecognised opcodes fall back to R so they carry a zero immediate.
  function automatic imm_type_e opc_imm_type(input logic [6:0] opc);
    imm_type_e t;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: t = IMM_I;
      OPC_STORE:                                                t = IMM_S;
      OPC_BRANCH:                                               t = IMM_B;
      OPC_LUI, OPC_AUIPC:                                       t = IMM_U;
      OPC_JAL:                                                  t = IMM_J;
      default:                                                  t = IMM_R;
    endcase
    return t;
  endfunction

  function automatic logic opc_known(input logic [6:0] opc);
    return opc inside {OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                       OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready_o is registered so the
// downstream ready never reaches the upstream handshake combinationally.
module dec_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;
  logic           ready_q;
  logic           valid_q;
  logic           in_xfer;
  logic           out_xfer;

  assign in_xfer  = in_valid_i & ready_q;
  assign out_xfer = valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q  <= in_data_i;
            state_q <= ONE;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data_i;
          end else if (in_xfer) begin
            skid_q  <= in_data_i;
            state_q <= FULL;
            ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/immed_gen.sv
// Builds every sign-extended RV32 immediate format from one instruction word.
module immed_gen (
  input  logic [31:0] inst_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_s_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o,
  output logic [31:0] imm_j_o
);

  assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_o = {inst_i[31:12], 12'b0};
  assign imm_j_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

endmodule

// File: rtl/imm_decode_stage.sv
// Decode front end: classifies the opcode, selects the immediate and buffers the
// result through a skid buffer. Define ILLEGAL_CHECK_EN to carry an illegal-opcode flag.
module imm_decode_stage #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     PC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fet_valid_i,
  output logic            fet_ready_o,
  input  logic [31:0]     fet_inst_i,
  input  logic [XLEN-1:0] fet_pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [31:0]     dec_inst_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_imm_o,
  output logic [2:0]      dec_imm_type_o,
  output logic [4:0]      dec_rs1_o,
  output logic [4:0]      dec_rs2_o,
  output logic [4:0]      dec_rd_o,
  output logic            dec_illegal_o
);
  import core_dec_pkg::*;

  if (XLEN != 32) begin : g_xlen_check
    $error("imm_decode_stage supports only XLEN=32");
  end

  logic [6:0]      opc;
  imm_type_e       type_sel;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm_sel;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_type;

  assign opc      = fet_inst_i[6:0];
  assign type_sel = opc_imm_type(opc);

  immed_gen u_immed_gen (
    .inst_i  (fet_inst_i),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u),
    .imm_j_o (imm_j)
  );

  always_comb begin
    imm_sel = '0;
    case (type_sel)
      IMM_I:   imm_sel = imm_i;
      IMM_S:   imm_sel = imm_s;
      IMM_B:   imm_sel = imm_b;
      IMM_U:   imm_sel = imm_u;
      IMM_J:   imm_sel = imm_j;
      default: imm_sel = '0;
    endcase
  end

`ifdef ILLEGAL_CHECK_EN
  localparam int unsigned PAY_W = 1 + 3 + 2 * XLEN + 32;
  logic illegal;
  logic out_illegal;
  assign illegal = !opc_known(opc) || (fet_inst_i[1:0] != 2'b11);
`else
  localparam int unsigned PAY_W = 3 + 2 * XLEN + 32;
`endif

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;

`ifdef ILLEGAL_CHECK_EN
  assign in_pay = {illegal, type_sel, imm_sel, fet_pc_i, fet_inst_i};
  assign {out_illegal, out_type, dec_imm_o, out_pc, dec_inst_o} = out_pay;
  assign dec_illegal_o = out_illegal;
`else
  assign in_pay = {type_sel, imm_sel, fet_pc_i, fet_inst_i};
  assign {out_type, dec_imm_o, out_pc, dec_inst_o} = out_pay;
  assign dec_illegal_o = 1'b0;
`endif

  dec_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (fet_valid_i),
    .in_ready_o  (fet_ready_o),
    .in_data_i   (in_pay),
    .out_valid_o (dec_valid_o),
    .out_ready_i (dec_ready_i),
    .out_data_o  (out_pay)
  );

  assign dec_pc_o       = dec_valid_o ? out_pc : PC_RESET;
  assign dec_imm_type_o = out_type;
  assign dec_rs1_o      = dec_inst_o[19:15];
  assign dec_rs2_o      = dec_inst_o[24:20];
  assign dec_rd_o       = dec_inst_o[11:7];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed RV32 immediates, backpressure,
// flush, reset and a randomized run against a queue-based reference model.
module tb_imm_decode_stage;

  localparam logic [31:0] PC_RST = 32'h8000_0000;

  logic        clk, rst_n, flush, fet_valid, fet_ready, dec_valid, dec_ready, dec_illegal;
  logic [31:0] fet_inst, fet_pc, dec_inst, dec_pc, dec_imm;
  logic [2:0]  dec_imm_type;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;

  txn_t q[$];
  bit   ready_m = 1'b1;

  imm_decode_stage #(
    .XLEN     (32),
    .PC_RESET (PC_RST)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .fet_valid_i    (fet_valid),
    .fet_ready_o    (fet_ready),
    .fet_inst_i     (fet_inst),
    .fet_pc_i       (fet_pc),
    .dec_valid_o    (dec_valid),
    .dec_ready_i    (dec_ready),
    .dec_inst_o     (dec_inst),
    .dec_pc_o       (dec_pc),
    .dec_imm_o      (dec_imm),
    .dec_imm_type_o (dec_imm_type),
    .dec_rs1_o      (dec_rs1),
    .dec_rs2_o      (dec_rs2),
    .dec_rd_o       (dec_rd),
    .dec_illegal_o  (dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_type(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: return 1;
      7'h23:                             return 2;
      7'h63:                             return 3;
      7'h37, 7'h17:                      return 4;
      7'h6F:                             return 5;
      default:                           return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    int r;
    s = w;
    case (ref_type(w))
      1: r = s >>> 20;
      2: r = ((s >>> 25) <<< 5) | int'(w[11:7]);
      3: r = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
      4: r = s & 32'hFFFF_F000;
      5: r = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
`ifdef ILLEGAL_CHECK_EN
    return !(w[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                            7'h63, 7'h67, 7'h6F, 7'h73});
`else
    return 1'b0 & w[0];
`endif
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                               7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F, 7'h10};
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opcs[$urandom_range(0, 12)];
    return w;
  endfunction

  // One clock: the model sees the same inputs the DUT samples at the edge.
  task automatic step();
    bit in_x, out_x;
    @(posedge clk);
    in_x  = fet_valid && ready_m;
    out_x = (q.size() != 0) && dec_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back('{inst: fet_inst, pc: fet_pc});
    end
    ready_m = (q.size() < 2);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; fet_valid = 1'b0; dec_ready = 1'b0; fet_inst = '0; fet_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
    n_checks++; if (fet_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", fet_ready); end
    n_checks++; if (dec_pc !== PC_RST) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", dec_pc, PC_RST); end
    n_checks++; if (dec_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", dec_inst); end
    n_checks++; if (dec_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm got=%h exp=0", dec_imm); end
    n_checks++; if (dec_imm_type !== 3'd0) begin n_fail++; $display("FAIL reset_type got=%0d exp=0", dec_imm_type); end
    n_checks++; if (dec_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", dec_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ready_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode_vectors();
    logic [31:0] insts [4] = '{32'hFFF0_0093, 32'hFE11_2E23, 32'h0000_0863, 32'h1234_52B7};
    logic [31:0] imms  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0010, 32'h1234_5000};
    int          types [4] = '{1, 2, 3, 4};
    int          rds   [4] = '{1, 28, 16, 5};
    int          rs1s  [4] = '{0, 2, 0, 8};
    int          rs2s  [4] = '{31, 1, 0, 3};
    for (int i = 0; i < 4; i++) begin
      fet_valid = 1'b1; fet_inst = insts[i]; fet_pc = 32'h100 + 32'(4 * i); dec_ready = 1'b1;
      step();
      fet_valid = 1'b0;
      n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid got=%b exp=1", i, dec_valid); end
      n_checks++; if (dec_imm !== imms[i]) begin n_fail++; $display("FAIL vec%0d_imm got=%h exp=%h", i, dec_imm, imms[i]); end
      n_checks++; if (int'(dec_imm_type) != types[i]) begin n_fail++; $display("FAIL vec%0d_type got=%0d exp=%0d", i, dec_imm_type, types[i]); end
      n_checks++; if (int'(dec_rd) != rds[i] || int'(dec_rs1) != rs1s[i] || int'(dec_rs2) != rs2s[i]) begin
        n_fail++; $display("FAIL vec%0d_regs got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, dec_rd, dec_rs1, dec_rs2, rds[i], rs1s[i], rs2s[i]);
      end
      n_checks++; if (dec_pc !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL vec%0d_pc got=%h exp=%h", i, dec_pc, 32'h100 + 32'(4 * i)); end
      step();
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_drain got=%b exp=0", i, dec_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = 32'h0041_0113; b = 32'h0020_8233; c = 32'h0000_006F;
    dec_ready = 1'b0;
    fet_valid = 1'b1; fet_inst = a; fet_pc = 32'h200;
    step();
    n_checks++; if (fet_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%b exp=1", fet_ready); end
    fet_inst = b; fet_pc = 32'h204;
    step();
    n_checks++; if (fet_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got=%b exp=0", fet_ready); end
    fet_inst = c; fet_pc = 32'h208;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dec_inst !== a || dec_pc !== 32'h200 || dec_imm !== ref_imm(a) || dec_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_stable inst=%h pc=%h imm=%h exp inst=%h pc=200 imm=%h", dec_inst, dec_pc, dec_imm, a, ref_imm(a));
      end
    end
    fet_valid = 1'b0; dec_ready = 1'b1;
    step();
    n_checks++; if (dec_inst !== b || dec_pc !== 32'h204 || dec_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second inst=%h pc=%h exp inst=%h pc=204", dec_inst, dec_pc, b);
    end
    step();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", dec_valid); end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0; fet_valid = 1'b1;
    fet_inst = 32'h0010_0093; fet_pc = 32'h300; step();
    fet_inst = 32'h0020_0113; fet_pc = 32'h304; step();
    flush = 1'b1; fet_inst = 32'h0030_0193; fet_pc = 32'h308;
    step();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", dec_valid); end
    n_checks++; if (fet_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", fet_ready); end
    flush = 1'b0; fet_valid = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_residue got=%b pc=%h exp=0", dec_valid, dec_pc); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w [3] = '{32'h0000_007F, 32'h0000_0010, 32'hFFF0_0093};
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fet_valid = 1'b1; fet_inst = w[i]; fet_pc = 32'h400;
      step();
      fet_valid = 1'b0;
      n_checks++; if (dec_illegal !== ref_illegal(w[i])) begin n_fail++; $display("FAIL illegal%0d got=%b exp=%b", i, dec_illegal, ref_illegal(w[i])); end
      n_checks++; if (dec_imm !== ref_imm(w[i])) begin n_fail++; $display("FAIL illegal%0d_imm got=%h exp=%h", i, dec_imm, ref_imm(w[i])); end
      step();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      fet_valid = ($urandom_range(0, 9) < 7);
      dec_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      fet_inst  = rand_inst();
      fet_pc    = $urandom & 32'hFFFF_FFFC;
      step();
      n_checks++; if (dec_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, dec_valid, q.size() != 0); end
      n_checks++; if (fet_ready !== ready_m) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, fet_ready, ready_m); end
      if (q.size() != 0) begin
        n_checks++; if (dec_inst !== q[0].inst || dec_pc !== q[0].pc) begin
          n_fail++; $display("FAIL rnd_payload cyc=%0d inst=%h pc=%h exp inst=%h pc=%h", cyc, dec_inst, dec_pc, q[0].inst, q[0].pc);
        end
        n_checks++; if (dec_imm !== ref_imm(q[0].inst) || int'(dec_imm_type) != ref_type(q[0].inst)) begin
          n_fail++; $display("FAIL rnd_imm cyc=%0d imm=%h type=%0d exp imm=%h type=%0d", cyc, dec_imm, dec_imm_type, ref_imm(q[0].inst), ref_type(q[0].inst));
        end
        n_checks++; if (dec_illegal !== ref_illegal(q[0].inst)) begin
          n_fail++; $display("FAIL rnd_illegal cyc=%0d got=%b exp=%b", cyc, dec_illegal, ref_illegal(q[0].inst));
        end
      end else begin
        n_checks++; if (dec_pc !== PC_RST) begin n_fail++; $display("FAIL rnd_empty_pc cyc=%0d got=%h exp=%h", cyc, dec_pc, PC_RST); end
      end
    end
    idle_inputs();
    dec_ready = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_reset_midflight();
    dec_ready = 1'b0; fet_valid = 1'b1;
    fet_inst = 32'h0050_0293; fet_pc = 32'h500; step();
    fet_inst = 32'h0060_0313; fet_pc = 32'h504; step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", dec_valid); end
    n_checks++; if (fet_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", fet_ready); end
    n_checks++; if (dec_pc !== PC_RST || dec_inst !== 32'h0) begin n_fail++; $display("FAIL rstmid_payload pc=%h inst=%h exp pc=%h inst=0", dec_pc, dec_inst, PC_RST); end
    q.delete();
    ready_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fet_inst = 32'h0070_0393; fet_pc = 32'h600; fet_valid = 1'b1;
    step();
    fet_valid = 1'b0;
    n_checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h0070_0393 || dec_pc !== 32'h600) begin
      n_fail++; $display("FAIL rstmid_resume valid=%b inst=%h pc=%h exp 1/00700393/600", dec_valid, dec_inst, dec_pc);
    end
    dec_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_decode_vectors();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
